except_entry_ctrl: RTL and testbench
====================================

EXCEPT_ENTRY_CTRL -- requirements
Module: except_entry_ctrl

Interface
REQ-001 SHALL have ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- estat  in  32  ESTAT CSR value: IS[12:0], Ecode[21:16], EsubCode[30:22]
- ecfg_lie  in  13  ECFG local interrupt enables
- crmd_plv  in  2  current CRMD.PLV
- crmd_ie  in  1  current CRMD.IE
- prmd_pplv  in  2  PRMD.PPLV
- prmd_pie  in  1  PRMD.PIE
- era_in  in  32  ERA CSR value
- eentry  in  32  general exception entry address
- tlbrentry  in  32  TLB refill entry address
- commit_valid  in  1  an instruction is in the commit slot
- commit_pc  in  32  PC of the commit-slot instruction
- commit_except  in  1  commit-slot instruction carries an exception
- commit_ertn  in  1  commit-slot instruction is ERTN
- flush_done  in  1  pipeline drained
- commit_kill  out  1  commit-slot instruction SHALL NOT retire (combinational)
- flush_req  out  1  request pipeline flush
- busy  out  1  state != IDLE
- crmd_wr_en / crmd_plv_o[1:0] / crmd_ie_o  out  CRMD update
- prmd_wr_en / prmd_pplv_o[1:0] / prmd_pie_o  out  PRMD update
- era_wr_en / era_o[31:0]  out  ERA update
- redirect_valid / redirect_pc[31:0]  out  fetch redirect

Function
REQ-002 SHALL compute int_pend = crmd_ie & |(estat[12:0] & ecfg_lie).
REQ-003 SHALL implement FSM states IDLE, DRAIN, ENTER, RETURN.
REQ-004 IDLE, commit_valid=1: priority commit_except > int_pend > commit_ertn; winner SHALL assert commit_kill same cycle, latch commit_pc into pc_q, latch kind (EXC/INT/ERTN), next state DRAIN.
REQ-005 IDLE, commit_valid=0: no action; int_pend alone SHALL NOT leave IDLE.
REQ-006 ERTN kill: ERTN taken is consumed; pc_q unused for ERTN.
REQ-007 DRAIN: flush_req=1 every cycle; on flush_done=1 go ENTER (EXC/INT) or RETURN (ERTN); flush_done outside DRAIN SHALL be ignored.
REQ-008 ENTER lasts exactly one cycle, asserting together: prmd_wr_en=1, prmd_pplv_o=crmd_plv, prmd_pie_o=crmd_ie; crmd_wr_en=1, crmd_plv_o=0, crmd_ie_o=0; era_wr_en=1, era_o=pc_q; redirect_valid=1; then IDLE.
REQ-009 ENTER redirect_pc SHALL be tlbrentry when kind=EXC and estat[21:16]=6'h3f, else eentry (INT always eentry).
REQ-010 RETURN lasts one cycle: crmd_wr_en=1, crmd_plv_o=prmd_pplv, crmd_ie_o=prmd_pie; redirect_valid=1, redirect_pc=era_in; prmd/era wr_en=0; then IDLE.
REQ-011 commit_kill SHALL be 1 in all non-IDLE states regardless of commit_valid.
REQ-012 All write enables, redirect_valid, flush_req SHALL be 0 except in states listed above; data outputs 0 when enable is 0.
REQ-013 ENTER/RETURN SHALL sample estat/CSR inputs in that cycle (not at IDLE latch).
REQ-014 Minimum entry latency commit->redirect: 2 cycles (IDLE take, DRAIN with flush_done=1, ENTER).
REQ-015 busy SHALL equal (state != IDLE).

Reset
REQ-016 rst_n=0 SHALL force IDLE, pc_q=0, kind=EXC, all outputs 0, asynchronously, including mid-DRAIN/ENTER; no CSR write or redirect after release until a new take.

Verification
REQ-017 Exception: commit_valid=1, commit_except=1, commit_pc=0x1C00_0100, crmd_plv=3, crmd_ie=1, estat[21:16]=0x0b, eentry=0x1C00_8000, flush_done one cycle later -> commit_kill same cycle, flush_req 1 cycle, then ENTER: era_o=0x1C00_0100, prmd {3,1}, crmd {0,0}, redirect_pc=0x1C00_8000.
REQ-018 TLBR: as REQ-017 with estat[21:16]=0x3f, tlbrentry=0x1C00_F000 -> redirect_pc=0x1C00_F000.
REQ-019 Interrupt: crmd_ie=1, estat[11]=1 (TI), ecfg_lie[11]=1, commit_valid=1, commit_pc=0x200 -> INT entry, era_o=0x200, redirect eentry; same with crmd_ie=0 -> no take.
REQ-020 Priority: commit_except=1, int_pend=1, commit_ertn=1 same cycle -> kind EXC; flush_done held 0 for 5 cycles -> flush_req stays 1, busy=1, no redirect.
REQ-021 ERTN: prmd_pplv=3, prmd_pie=1, era_in=0x1C00_0104 -> RETURN: crmd {3,1}, redirect_pc=0x1C00_0104, era_wr_en=0.
REQ-022 Reset mid-DRAIN: rst_n pulsed low -> all outputs 0 immediately, IDLE, no ENTER after release.

Source files
------------

// File: rtl/except_entry_ctrl.sv
// Exception / interrupt / ERTN entry sequencer: takes the commit-slot event, drains the
// pipeline, then performs the one-cycle CSR update and fetch redirect.
module except_entry_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] estat,
  input  logic [12:0] ecfg_lie,
  input  logic [1:0]  crmd_plv,
  input  logic        crmd_ie,
  input  logic [1:0]  prmd_pplv,
  input  logic        prmd_pie,
  input  logic [31:0] era_in,
  input  logic [31:0] eentry,
  input  logic [31:0] tlbrentry,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        commit_except,
  input  logic        commit_ertn,
  input  logic        flush_done,
  output logic        commit_kill,
  output logic        flush_req,
  output logic        busy,
  output logic        crmd_wr_en,
  output logic [1:0]  crmd_plv_o,
  output logic        crmd_ie_o,
  output logic        prmd_wr_en,
  output logic [1:0]  prmd_pplv_o,
  output logic        prmd_pie_o,
  output logic        era_wr_en,
  output logic [31:0] era_o,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE, DRAIN, ENTER, RETURN} state_t;
  typedef enum logic [1:0] {K_EXC, K_INT, K_ERTN} kind_t;

  state_t      state;
  kind_t       kind;
  logic [31:0] pc_q;
  logic        int_pend;
  logic        take;
  logic        is_tlbr;
  logic        unused_estat;

  assign int_pend     = crmd_ie & (|(estat[12:0] & ecfg_lie));
  assign take         = (state == IDLE) & commit_valid & (commit_except | int_pend | commit_ertn);
  assign is_tlbr      = (kind == K_EXC) && (estat[21:16] == 6'h3f);
  assign unused_estat = ^{estat[31:22], estat[15:13]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      kind  <= K_EXC;
      pc_q  <= 32'h0;
    end else begin
      case (state)
        IDLE: if (take) begin
          pc_q  <= commit_pc;
          state <= DRAIN;
          if (commit_except)  kind <= K_EXC;
          else if (int_pend)  kind <= K_INT;
          else                kind <= K_ERTN;
        end
        DRAIN: if (flush_done) state <= (kind == K_ERTN) ? RETURN : ENTER;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the current state; ENTER/RETURN data comes from the CSR inputs of
  // that very cycle. Everything is gated by rst_n so reset clears them without a clock.
  always_comb begin
    commit_kill    = 1'b0;
    flush_req      = 1'b0;
    busy           = 1'b0;
    crmd_wr_en     = 1'b0;
    crmd_plv_o     = 2'b00;
    crmd_ie_o      = 1'b0;
    prmd_wr_en     = 1'b0;
    prmd_pplv_o    = 2'b00;
    prmd_pie_o     = 1'b0;
    era_wr_en      = 1'b0;
    era_o          = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    state_dbg      = 2'b00;
    if (rst_n) begin
      state_dbg   = state;
      busy        = (state != IDLE);
      commit_kill = (state != IDLE) | take;
      case (state)
        DRAIN: flush_req = 1'b1;
        ENTER: begin
          prmd_wr_en     = 1'b1;
          prmd_pplv_o    = crmd_plv;
          prmd_pie_o     = crmd_ie;
          crmd_wr_en     = 1'b1;
          era_wr_en      = 1'b1;
          era_o          = pc_q;
          redirect_valid = 1'b1;
          redirect_pc    = is_tlbr ? tlbrentry : eentry;
        end
        RETURN: begin
          crmd_wr_en     = 1'b1;
          crmd_plv_o     = prmd_pplv;
          crmd_ie_o      = prmd_pie;
          redirect_valid = 1'b1;
          redirect_pc    = era_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_except_entry_ctrl.sv
// Bench for except_entry_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model (pending event, drained flag, final cycle).
module tb_except_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] estat, era_in, eentry, tlbrentry, commit_pc;
  logic [12:0] ecfg_lie;
  logic [1:0]  crmd_plv, prmd_pplv;
  logic        crmd_ie, prmd_pie, commit_valid, commit_except, commit_ertn, flush_done;
  logic        commit_kill, flush_req, busy, crmd_wr_en, crmd_ie_o, prmd_wr_en, prmd_pie_o;
  logic        era_wr_en, redirect_valid;
  logic [1:0]  crmd_plv_o, prmd_pplv_o, state_dbg;
  logic [31:0] era_o, redirect_pc;

  int vectors = 0;
  int miscompares = 0;

  except_entry_ctrl dut (
    .clk(clk), .rst_n(rst_n), .estat(estat), .ecfg_lie(ecfg_lie), .crmd_plv(crmd_plv),
    .crmd_ie(crmd_ie), .prmd_pplv(prmd_pplv), .prmd_pie(prmd_pie), .era_in(era_in),
    .eentry(eentry), .tlbrentry(tlbrentry), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_except(commit_except), .commit_ertn(commit_ertn),
    .flush_done(flush_done), .commit_kill(commit_kill), .flush_req(flush_req), .busy(busy),
    .crmd_wr_en(crmd_wr_en), .crmd_plv_o(crmd_plv_o), .crmd_ie_o(crmd_ie_o),
    .prmd_wr_en(prmd_wr_en), .prmd_pplv_o(prmd_pplv_o), .prmd_pie_o(prmd_pie_o),
    .era_wr_en(era_wr_en), .era_o(era_o), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [12:0] ctrl;
  assign ctrl = {commit_kill, flush_req, busy, crmd_wr_en, crmd_plv_o, crmd_ie_o,
                 prmd_wr_en, prmd_pplv_o, prmd_pie_o, era_wr_en, redirect_valid};

  // reference model: one outstanding event (kind 0=EXC 1=INT 2=ERTN)
  bit          m_pend, m_final;
  int          m_kind;
  logic [31:0] m_pc;
  logic [12:0] e_ctrl;
  logic [31:0] e_era, e_rpc;
  bit          m_take;
  int          m_new_kind;

  task automatic model_reset();
    m_pend = 0; m_final = 0; m_kind = 0; m_pc = 0;
  endtask

  task automatic model_expect();
    bit ip, ent, ret;
    ip  = crmd_ie && ((estat[12:0] & ecfg_lie) != 13'h0);
    m_take = !m_pend && commit_valid && (commit_except || ip || commit_ertn);
    m_new_kind = commit_except ? 0 : (ip ? 1 : 2);
    ent = m_final && m_kind != 2;
    ret = m_final && m_kind == 2;
    e_ctrl = {m_pend || m_take, m_pend && !m_final, m_pend, ent || ret,
              ret ? prmd_pplv : 2'b00, ret ? prmd_pie : 1'b0,
              ent, ent ? crmd_plv : 2'b00, ent ? crmd_ie : 1'b0, ent, ent || ret};
    e_era = ent ? m_pc : 32'h0;
    if (ret) e_rpc = era_in;
    else if (ent) e_rpc = (m_kind == 0 && estat[21:16] == 6'h3f) ? tlbrentry : eentry;
    else e_rpc = 32'h0;
  endtask

  task automatic model_advance();
    if (m_final) begin m_pend = 0; m_final = 0; end
    else if (m_pend && flush_done) m_final = 1;
    else if (m_take) begin m_pend = 1; m_kind = m_new_kind; m_pc = commit_pc; end
  endtask

  // driver tasks
  task automatic drive_quiet();
    estat = 0; ecfg_lie = 0; crmd_plv = 0; crmd_ie = 0; prmd_pplv = 0; prmd_pie = 0;
    era_in = 0; eentry = 32'h1C00_8000; tlbrentry = 32'h1C00_F000; commit_pc = 0;
    commit_valid = 0; commit_except = 0; commit_ertn = 0; flush_done = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_quiet();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if (ctrl !== 13'h0 || era_o !== 32'h0 || redirect_pc !== 32'h0 || state_dbg !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: ctrl=%h era=%h rpc=%h st=%0d required all 0",
               ctrl, era_o, redirect_pc, state_dbg);
    end
  endtask

  task automatic test_exception(input logic [5:0] ecode, input logic [31:0] exp_rpc,
                                input string name);
    do_reset();
    commit_valid = 1; commit_except = 1; commit_pc = 32'h1C00_0100;
    crmd_plv = 2'd3; crmd_ie = 1; estat = {10'h0, ecode, 16'h0};
    #1;
    vectors++;
    if (commit_kill !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_take: kill=%b busy=%b required 1 0", name, commit_kill, busy);
    end
    @(negedge clk);
    commit_valid = 0; commit_except = 0; flush_done = 1;
    #1;
    vectors++;
    if (flush_req !== 1'b1 || busy !== 1'b1 || redirect_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drain: flush=%b busy=%b rv=%b required 1 1 0",
               name, flush_req, busy, redirect_valid);
    end
    @(negedge clk);
    flush_done = 0;
    #1;
    vectors++;
    if (ctrl !== 13'b1_0_1_1_00_0_1_11_1_1_1 || era_o !== 32'h1C00_0100 || redirect_pc !== exp_rpc) begin
      miscompares++;
      $display("FAIL %s_enter: ctrl=%b era=%h rpc=%h required 1011000111111 1c000100 %h",
               name, ctrl, era_o, redirect_pc, exp_rpc);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0 || crmd_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: busy=%b rv=%b crmd_wr=%b required 0 0 0",
               name, busy, redirect_valid, crmd_wr_en);
    end
  endtask

  task automatic test_interrupt();
    do_reset();
    crmd_ie = 1; estat = 32'h0000_0800; ecfg_lie = 13'h0800; commit_valid = 1; commit_pc = 32'h200;
    #1;
    vectors++;
    if (commit_kill !== 1'b1) begin
      miscompares++;
      $display("FAIL int_take: kill=%b required 1", commit_kill);
    end
    @(negedge clk);
    commit_valid = 0; flush_done = 1;
    @(negedge clk);
    flush_done = 0;
    #1;
    vectors++;
    if (era_wr_en !== 1'b1 || era_o !== 32'h200 || redirect_pc !== 32'h1C00_8000 ||
        prmd_pie_o !== 1'b1 || crmd_ie_o !== 1'b0) begin
      miscompares++;
      $display("FAIL int_enter: era_wr=%b era=%h rpc=%h pie=%b ie=%b required 1 200 1c008000 1 0",
               era_wr_en, era_o, redirect_pc, prmd_pie_o, crmd_ie_o);
    end
    @(negedge clk);
    crmd_ie = 0; commit_valid = 1;
    #1;
    vectors++;
    if (commit_kill !== 1'b0) begin
      miscompares++;
      $display("FAIL int_masked_kill: kill=%b required 0", commit_kill);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL int_masked_busy: busy=%b required 0", busy);
    end
    commit_valid = 0;
  endtask

  task automatic test_priority();
    do_reset();
    commit_valid = 1; commit_except = 1; commit_ertn = 1; commit_pc = 32'h1C00_0300;
    crmd_ie = 1; estat = 32'h1; ecfg_lie = 13'h1; prmd_pplv = 2'd2;
    @(negedge clk);
    commit_valid = 0; commit_except = 0; commit_ertn = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (flush_req !== 1'b1 || busy !== 1'b1 || redirect_valid !== 1'b0 || commit_kill !== 1'b1) begin
        miscompares++;
        $display("FAIL prio_hold%0d: flush=%b busy=%b rv=%b kill=%b required 1 1 0 1",
                 i, flush_req, busy, redirect_valid, commit_kill);
      end
      @(negedge clk);
    end
    flush_done = 1;
    @(negedge clk);
    flush_done = 0;
    #1;
    vectors++;
    if (prmd_wr_en !== 1'b1 || era_o !== 32'h1C00_0300 || crmd_plv_o !== 2'd0) begin
      miscompares++;
      $display("FAIL prio_kind: prmd_wr=%b era=%h plv=%0d required 1 1c000300 0",
               prmd_wr_en, era_o, crmd_plv_o);
    end
  endtask

  task automatic test_ertn();
    do_reset();
    commit_valid = 1; commit_ertn = 1; commit_pc = 32'hDEAD_0000;
    prmd_pplv = 2'd3; prmd_pie = 1; era_in = 32'h1C00_0104; crmd_plv = 2'd0;
    #1;
    vectors++;
    if (commit_kill !== 1'b1) begin
      miscompares++;
      $display("FAIL ertn_take: kill=%b required 1", commit_kill);
    end
    @(negedge clk);
    commit_valid = 0; commit_ertn = 0; flush_done = 1;
    @(negedge clk);
    flush_done = 0;
    #1;
    vectors++;
    if (ctrl !== 13'b1_0_1_1_11_1_0_00_0_0_1 || redirect_pc !== 32'h1C00_0104 || era_o !== 32'h0) begin
      miscompares++;
      $display("FAIL ertn_return: ctrl=%b rpc=%h era=%h required 1011111000001 1c000104 0",
               ctrl, redirect_pc, era_o);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    commit_valid = 1; commit_except = 1; commit_pc = 32'h1C00_0500;
    @(negedge clk);
    #1;
    vectors++;
    if (flush_req !== 1'b1) begin
      miscompares++;
      $display("FAIL middrain_pre: flush=%b required 1", flush_req);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (ctrl !== 13'h0 || era_o !== 32'h0 || redirect_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL middrain_async: ctrl=%b era=%h rpc=%h required 0", ctrl, era_o, redirect_pc);
    end
    @(negedge clk);
    commit_valid = 0; commit_except = 0; flush_done = 1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (ctrl !== 13'h0) begin
        miscompares++;
        $display("FAIL middrain_after%0d: ctrl=%b required 0", i, ctrl);
      end
      @(negedge clk);
    end
    flush_done = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      estat        = {$urandom_range(0, 1) ? 6'h3f : 6'($urandom), 16'($urandom)} & 32'hFFFF_FFFF;
      estat[12:0]  = ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'h0;
      ecfg_lie     = 13'($urandom);
      crmd_plv     = 2'($urandom); crmd_ie = 1'($urandom);
      prmd_pplv    = 2'($urandom); prmd_pie = 1'($urandom);
      era_in       = $urandom; eentry = $urandom; tlbrentry = $urandom; commit_pc = $urandom;
      commit_valid = ($urandom_range(0, 1) == 0);
      commit_except = ($urandom_range(0, 4) == 0);
      commit_ertn  = ($urandom_range(0, 4) == 0);
      flush_done   = ($urandom_range(0, 2) == 0);
      #1;
      model_expect();
      vectors++;
      if (ctrl !== e_ctrl) begin
        miscompares++;
        $display("FAIL rand_ctrl@%0d: got %b required %b", n, ctrl, e_ctrl);
      end
      vectors++;
      if (era_o !== e_era || redirect_pc !== e_rpc) begin
        miscompares++;
        $display("FAIL rand_data@%0d: era=%h rpc=%h required %h %h", n, era_o, redirect_pc, e_era, e_rpc);
      end
      @(posedge clk);
      model_advance();
      @(negedge clk);
    end
    drive_quiet();
  endtask

  initial begin
    drive_quiet();
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_exception(6'h0b, 32'h1C00_8000, "exc");
    test_exception(6'h3f, 32'h1C00_F000, "tlbr");
    test_interrupt();
    test_priority();
    test_ertn();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
